muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers, used by the multi-cycle MIPS core.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- The control FSM issues an operation with a start pulse, stalls while busy=1, and reads hi/lo once done pulses.
- One bit per cycle (shift-add multiply, restoring divide); operand width is set by parameter.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset: asynchronous, active-high
- start  input  1  issue strobe, sampled only in IDLE
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse: hi/lo updated
- div_by_zero  output  1  valid with done; 1 when the divide had b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. An operation in flight is abandoned and no partial result is written.
- States:
  - IDLE -> RUN when start=1 and op in {000..011}.
  - RUN -> RUN while counter != 0; RUN -> FIX when counter reaches 0.
  - FIX -> IDLE always.
- Edge 0 is the edge that samples start=1 in IDLE.
  - For mult/div ops it latches |a| and |b| (signed ops) or raw a and b (unsigned ops), plus sign flags.
  - It also sets counter=WIDTH and busy=1.
- RUN: one iteration per edge, WIDTH edges in total (edges 1..WIDTH).
  - Multiply: 2*WIDTH-bit shift-add.
  - Divide: restoring shift-subtract; remainder in the upper half, quotient in the lower half.
- FIX (edge WIDTH+1):
  - Applies sign correction.
  - Multiply: product negated if the operand signs differ.
  - Divide: quotient negated if the signs differ; remainder takes the sign of the dividend.
  - Writes hi/lo, drives done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: done is high in the cycle after edge WIDTH+1, i.e. WIDTH+2 edges after issue. busy is high for the cycles after edges 0..WIDTH.
- Result placement: multiply puts the upper half in hi and the lower half in lo. Divide puts the remainder in hi and the quotient in lo.
- Divide by zero (b==0, DIV or DIVU): lo = all ones, hi = raw a, no sign fix, div_by_zero=1 in the done cycle.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): lo = -2^(WIDTH-1), hi = 0, div_by_zero=0. This is the natural wrap; no trap is raised.
- MTHI / MTLO:
  - Accepted in IDLE only; the selected register is written at edge 0 with a; the other register is unchanged.
  - No busy, no done.
- start while busy=1 (any op): ignored, with no effect on state or results.
- Illegal op 110/111 with start=1: ignored, stays in IDLE.
- hi/lo hold their values at all times except at the FIX edge, an MTHI/MTLO edge, or reset.
- div_by_zero clears to 0 on the edge after done.
- Back-to-back: start may be asserted in the done cycle; it is accepted because the state is already IDLE.

Decomposition:
- Shared package/include mdu_defs:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  - state encodings: S_IDLE, S_RUN, S_FIX
- One combinational sub-module, mdu_iter, implements one iteration.
  - Inputs: mode (mul/div), the 2*WIDTH-bit accumulator and the operand.
  - Output: the next accumulator.
- The top holds the FSM, counter, sign flags, sign correction and the HI/LO registers.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 edges after issue; busy low in the done cycle.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=0xFFFFFFF9 b=2 -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV a=0x00001234 b=0 -> lo=0xFFFFFFFF, hi=0x00001234, div_by_zero=1 for one cycle. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- MULTU in flight, then start with DIV at RUN cycle 5 -> ignored, and the MULTU result is still correct. MTHI a=0xA5 from IDLE -> hi=0x000000A5 next cycle, lo unchanged, no done.
- rst asserted mid-RUN (cycle 10), not aligned to clk -> busy, done, hi and lo are all 0 immediately. After release, a fresh MULT 6*7 gives lo=42, hi=0.
- WIDTH=8 instance: DIV a=0x80 b=0xFF -> lo=0x80, hi=0x00; MULT 0x7F*0x7F -> hi=0x3F, lo=0x01; done 10 edges after issue; plus 1000 random ops checked against a reference model.

Source files
------------

// File: rtl/mdu_defs_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_defs;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_unit_iter.sv
// One iteration of the multiply/divide datapath on the 2*WIDTH accumulator.
// Multiply: acc = {partial product, remaining multiplier bits}, shifts right.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}, shifts left.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 mode_div,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     opnd,
   output logic [2*WIDTH-1:0]   acc_nxt
);

   logic [WIDTH:0] add_sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   // Shift-add step or restoring shift-subtract step.
   always_comb begin
      add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      rem_sh  = acc[2*WIDTH-1:WIDTH-1];
      diff    = rem_sh - {1'b0, opnd};
      if (mode_div) begin
         // diff[WIDTH] set means the trial subtract borrowed: keep the old remainder.
         if (diff[WIDTH]) begin
            acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end else begin
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end
      end else begin
         acc_nxt = {add_sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO handled here in one edge
// S_RUN  | one multiply/divide iteration per edge, counter counts down
// S_FIX  | sign correction, HI/LO write, done pulse
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   import mdu_defs::*;

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int W2    = 2 * WIDTH;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;
   logic             dbz_out_q, dbz_out_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [W2-1:0]    acc_iter;
   logic             signed_op;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .mode_div (is_div_q),
      .acc      (acc_q),
      .opnd     (opnd_q),
      .acc_nxt  (acc_iter)
   );

   // Operand magnitudes at issue and sign-corrected results at FIX.
   always_comb begin
      signed_op = ~op[0];
      abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
      abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
      prod_fix  = neg_res_q ? -acc_q : acc_q;
      quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix   = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
   end

   // FSM next state, iteration datapath and HI/LO update.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_out_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     state_d   = S_RUN;
                     cnt_d     = CNT_W'(WIDTH);
                     is_div_d  = op[1];
                     neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_rem_d = signed_op & op[1] & a[WIDTH-1];
                     dbz_d     = op[1] && (b == '0);
                     if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                        opnd_d = abs_b;
                     end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                     end
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            acc_d = acc_iter;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            dbz_out_d = dbz_q;
            if (is_div_q) begin
               // Divide by zero: remainder path already holds |a|, sign fix restores raw a.
               lo_d = dbz_q ? {WIDTH{1'b1}} : quo_fix;
               hi_d = rem_fix;
            end else begin
               hi_d = prod_fix[W2-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and register update; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         done_q    <= done_d;
         dbz_out_q <= dbz_out_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_out_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

   typedef struct packed {
      logic [63:0] hi;
      logic [63:0] lo;
      logic        dbz;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        start32 = 1'b0;
   logic [2:0]  op32 = '0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        busy32, done32, dbz32;
   logic [31:0] hi32, lo32;

   logic        start8 = 1'b0;
   logic [2:0]  op8 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, dbz8;
   logic [7:0]  hi8, lo8;

   int   total = 0;
   int   bad   = 0;
   exp_t q32[$];
   exp_t q8[$];

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic longint sx(input logic [63:0] v, input int w);
      longint t;
      t = longint'(v << (64 - w));
      return t >>> (64 - w);
   endfunction

   function automatic exp_t model(input int w, input logic [2:0] op,
                                  input logic [63:0] a, input logic [63:0] b);
      exp_t        e;
      logic [63:0] mask, pu;
      longint      sa, sb, q, r;
      mask = (64'd1 << w) - 64'd1;
      sa   = sx(a, w);
      sb   = sx(b, w);
      e    = '0;
      case (op)
         3'b000, 3'b001: begin
            if (op == 3'b000) pu = sa * sb;
            else              pu = (a & mask) * (b & mask);
            e.hi = (pu >> w) & mask;
            e.lo = pu & mask;
         end
         default: begin
            if ((b & mask) == 64'd0) begin
               e.dbz = 1'b1;
               e.lo  = mask;
               e.hi  = a & mask;
            end else if (op == 3'b010) begin
               q    = sa / sb;
               r    = sa % sb;
               e.lo = q & mask;
               e.hi = r & mask;
            end else begin
               e.lo = ((a & mask) / (b & mask)) & mask;
               e.hi = ((a & mask) % (b & mask)) & mask;
            end
         end
      endcase
      return e;
   endfunction

   // Results are compared when done pulses.
   always @(negedge clk) begin
      exp_t e;
      if (done32) begin
         if (q32.size() == 0) chk("done32_unexpected", 1, 0);
         else begin
            e = q32.pop_front();
            chk("hi32", hi32, e.hi);
            chk("lo32", lo32, e.lo);
            chk("dbz32", dbz32, e.dbz);
         end
      end
      if (done8) begin
         if (q8.size() == 0) chk("done8_unexpected", 1, 0);
         else begin
            e = q8.pop_front();
            chk("hi8", hi8, e.hi);
            chk("lo8", lo8, e.lo);
            chk("dbz8", dbz8, e.dbz);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the issue edge.
   task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push);
      start32 = 1'b1; op32 = op; a32 = a; b32 = b;
      if (push) q32.push_back(model(32, op, {32'd0, a}, {32'd0, b}));
      @(negedge clk);
      start32 = 1'b0;
   endtask

   task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      start8 = 1'b1; op8 = op; a8 = a; b8 = b;
      if (op < 3'd4) q8.push_back(model(8, op, {56'd0, a}, {56'd0, b}));
      @(negedge clk);
      start8 = 1'b0;
   endtask

   // n counts edges from the issue edge (=1) to the edge that raised done.
   task automatic wait_done32(output int n);
      n = 1;
      while (!done32 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done32) chk("timeout32", 0, 1);
   endtask

   task automatic wait_done8(output int n);
      n = 1;
      while (!done8 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done8) chk("timeout8", 0, 1);
   endtask

   initial begin
      int          n;
      logic [2:0]  rop;
      logic [7:0]  ra, rb;
      int          sel;

      #2;
      chk("rst_busy", busy32, 0);
      chk("rst_done", done32, 0);
      chk("rst_dbz", dbz32, 0);
      chk("rst_hi", hi32, 0);
      chk("rst_lo", lo32, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // MULTU max*max with latency and busy checks
      issue32(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
      chk("busy_run", busy32, 1);
      wait_done32(n);
      chk("lat32", n, 34);
      chk("busy_done_cycle", busy32, 0);
      @(negedge clk);

      // MTHI: hi written, lo unchanged, no done
      issue32(3'b100, 32'h000000A5, 32'h0, 0);
      chk("mthi_hi", hi32, 32'h000000A5);
      chk("mthi_lo", lo32, 32'h00000001);
      chk("mthi_busy", busy32, 0);
      chk("mthi_done", done32, 0);

      // MTLO
      issue32(3'b101, 32'hCAFE0001, 32'h0, 0);
      chk("mtlo_lo", lo32, 32'hCAFE0001);
      chk("mtlo_hi", hi32, 32'h000000A5);

      // illegal op ignored
      issue32(3'b110, 32'h11111111, 32'h22222222, 0);
      chk("illegal_busy", busy32, 0);
      chk("illegal_hi", hi32, 32'h000000A5);
      chk("illegal_lo", lo32, 32'hCAFE0001);

      // signed/unsigned directed cases, issued back-to-back in the done cycle
      issue32(3'b000, 32'hFFFFFFFD, 32'd7, 1);
      wait_done32(n);
      issue32(3'b010, 32'hFFFFFFF9, 32'd2, 1);
      wait_done32(n);
      issue32(3'b011, 32'hFFFFFFF9, 32'd2, 1);
      wait_done32(n);
      issue32(3'b010, 32'h00001234, 32'd0, 1);
      wait_done32(n);
      @(negedge clk);
      chk("dbz_clear", dbz32, 0);
      issue32(3'b010, 32'h80000000, 32'hFFFFFFFF, 1);
      wait_done32(n);
      chk("ovf_lat", n, 34);
      @(negedge clk);

      // start while busy is ignored
      issue32(3'b001, 32'h12345678, 32'h9ABCDEF0, 1);
      repeat (4) @(negedge clk);
      issue32(3'b010, 32'h00000064, 32'h00000003, 0);
      wait_done32(n);
      repeat (40) @(negedge clk);
      chk("q32_empty", q32.size(), 0);

      // asynchronous reset mid-RUN
      issue32(3'b001, 32'h0000FFFF, 32'h0000FFFF, 0);
      repeat (9) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_busy", busy32, 0);
      chk("arst_done", done32, 0);
      chk("arst_hi", hi32, 0);
      chk("arst_lo", lo32, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      repeat (40) @(negedge clk);
      chk("arst_no_done", q32.size(), 0);
      issue32(3'b000, 32'd6, 32'd7, 1);
      wait_done32(n);
      @(negedge clk);

      // WIDTH=8 directed
      issue8(3'b010, 8'h80, 8'hFF);
      wait_done8(n);
      issue8(3'b000, 8'h7F, 8'h7F);
      wait_done8(n);
      chk("lat8", n, 10);
      @(negedge clk);

      // WIDTH=8 random
      for (int i = 0; i < 1000; i++) begin
         rop = 3'($urandom_range(0, 3));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         sel = $urandom_range(0, 9);
         if (sel == 0) rb = 8'h00;
         if (sel == 1) begin ra = 8'h80; rb = 8'hFF; end
         issue8(rop, ra, rb);
         wait_done8(n);
      end
      @(negedge clk);
      chk("q8_empty", q8.size(), 0);
      chk("q32_final_empty", q32.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
